// File: rtl/reg_file_2r1w.sv
// RISC-V integer register file: two combinational read ports with write-through
// bypass, one synchronous write port, x0 hardwired to zero.
module reg_file_2r1w #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [WIDTH-1:0]  rs1_data,
   output logic [WIDTH-1:0]  rs2_data,
   input  logic              we,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [WIDTH-1:0]  rd_data,
   output logic [7:0]        wr_count
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:1]  wr_en;
   logic [WIDTH-1:0]  regs_q [DEPTH];
   logic [7:0]        wr_count_q;
   logic [7:0]        wr_count_d;
   logic              commit;
   logic [ADDR_W-1:0] rs_addr [2];
   logic [WIDTH-1:0]  rs_data [2];

   assign commit = we && (rd_addr != '0);

   // One-hot write decode; x0 has no enable at all, so its writes vanish here.
   genvar gi;
   generate
      for (gi = 1; gi < DEPTH; gi++) begin : g_dec
         assign wr_en[gi] = we && (rd_addr == ADDR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (wr_en[i]) regs_q[i] <= rd_data;
         end
      end
   end

   assign rs_addr[0] = rs1_addr;
   assign rs_addr[1] = rs2_addr;

   // Reset and x0 override everything; a matching non-x0 write shows through early.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         assign rs_data[gi] = (rst || (rs_addr[gi] == '0))          ? '0      :
                              (commit && (rd_addr == rs_addr[gi])) ? rd_data :
                                                                     regs_q[rs_addr[gi]];
      end
   endgenerate

   assign rs1_data = rs_data[0];
   assign rs2_data = rs_data[1];

   always_comb begin
      wr_count_d = wr_count_q;
      if (commit && (wr_count_q != 8'hFF)) wr_count_d = wr_count_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wr_count_q <= '0;
      else     wr_count_q <= wr_count_d;
   end

   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: stimulus pushes expected reads/count,
// a negedge monitor pops and compares against the live outputs.
module tb_reg_file_2r1w;
   logic        clk;
   logic        rst;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [31:0] rs1_data, rs2_data, rd_data;
   logic        we;
   logic [7:0]  wr_count;

   reg_file_2r1w #(.WIDTH(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_count(wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          tag;
      logic [31:0] e1;
      logic [31:0] e2;
      logic [7:0]  ec;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mregs [32];
   int          mcount;
   int          checks;
   int          failures;

   // Reference: what a reader sees right now, from architectural state and the pending write.
   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (rst)                               return 32'h0;
      if (a == 5'd0)                         return 32'h0;
      if (we && rd_addr == a)                return rd_data;
      return mregs[a];
   endfunction

   task automatic drive(input int tag, input logic r, input logic w, input logic [4:0] rd,
                        input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
      exp_t e;
      rst = r; we = w; rd_addr = rd; rd_data = d; rs1_addr = a1; rs2_addr = a2;
      if (r) begin
         for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
         mcount = 0;
      end
      e.tag = tag;
      e.e1  = exp_read(a1);
      e.e2  = exp_read(a2);
      e.ec  = 8'(mcount);
      sb.push_back(e);
      @(posedge clk);
      if (!r && w && rd != 5'd0) begin
         mregs[rd] = d;
         if (mcount < 255) mcount++;
      end
      #1;
   endtask

   // Monitor: one scoreboard entry per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (rs1_data !== e.e1) begin
               failures++;
               $display("FAIL rs1_data tag=%0d addr=%0d got=%h exp=%h", e.tag, rs1_addr, rs1_data, e.e1);
            end
            checks++;
            if (rs2_data !== e.e2) begin
               failures++;
               $display("FAIL rs2_data tag=%0d addr=%0d got=%h exp=%h", e.tag, rs2_addr, rs2_data, e.e2);
            end
            checks++;
            if (wr_count !== e.ec) begin
               failures++;
               $display("FAIL wr_count tag=%0d got=%0d exp=%0d", e.tag, wr_count, e.ec);
            end
            $display("txn tag=%0d rst=%0b we=%0b rd=%0d rs1=%0d:%h rs2=%0d:%h cnt=%0d",
                     e.tag, rst, we, rd_addr, rs1_addr, rs1_data, rs2_addr, rs2_data, wr_count);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic        r, w;
      logic [4:0]  rd, a1, a2;
      logic [31:0] d;
      checks = 0; failures = 0; mcount = 0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      rst = 1'b1; we = 1'b0; rd_addr = '0; rd_data = '0; rs1_addr = '0; rs2_addr = '0;
      @(posedge clk); #1;

      // Reset: every address on both ports reads zero, even with a write presented.
      for (int i = 0; i < 32; i++)
         drive(1, 1'b1, 1'(i), 5'(i), 32'hA5A5_0000 + 32'(i), 5'(i), 5'(31 - i));

      // Basic write then read.
      drive(2, 1'b0, 1'b1, 5'd5,  32'h15, 5'd0, 5'd0);
      drive(2, 1'b0, 1'b1, 5'd10, 32'h0A, 5'd0, 5'd0);
      drive(2, 1'b0, 1'b0, 5'd0,  32'h0,  5'd5, 5'd10);

      // x0 write is discarded and never bypassed.
      drive(3, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd5, 5'd0);
      drive(3, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd10);

      // Dual-port bypass.
      drive(4, 1'b0, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0);
      drive(4, 1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
      drive(4, 1'b0, 1'b0, 5'd0, 32'h0,  5'd7, 5'd7);

      // Fill, then async reset raised mid-cycle; the write held under reset is lost.
      for (int i = 1; i < 32; i++)
         drive(5, 1'b0, 1'b1, 5'(i), 32'(i), 5'(i), 5'd31);
      drive(5, 1'b1, 1'b0, 5'd0, 32'h0,  5'd3, 5'd31);
      drive(5, 1'b1, 1'b1, 5'd9, 32'h99, 5'd9, 5'd1);
      drive(5, 1'b0, 1'b0, 5'd0, 32'h0,  5'd9, 5'd1);
      drive(5, 1'b0, 1'b1, 5'd3, 32'h333, 5'd3, 5'd0);
      drive(5, 1'b0, 1'b0, 5'd0, 32'h0,  5'd3, 5'd9);

      // Saturation of the write counter.
      for (int i = 0; i < 300; i++)
         drive(6, 1'b0, 1'b1, 5'd1, $urandom, 5'd1, 5'($urandom_range(31, 0)));
      drive(6, 1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1);

      // Random traffic with occasional resets and idle-cycle garbage on the write port.
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(63, 0) == 0);
         w  = 1'($urandom_range(1, 0));
         rd = 5'($urandom_range(31, 0));
         d  = $urandom;
         a1 = ($urandom_range(2, 0) == 0) ? rd : 5'($urandom_range(31, 0));
         a2 = ($urandom_range(2, 0) == 0) ? rd : 5'($urandom_range(31, 0));
         drive(7, r, w, rd, d, a1, a2);
      end

      we = 1'b0;
      repeat (2) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
